// File: rtl/mem_arbiter.sv
// mem_arbiter: registered two-master arbiter in front of the single-port core memory.
//   Master 0 (execute stage) issues loads/stores of byte/half/word size.
//   Master 1 (fetch unit) issues word reads only.
//   Fixed priority goes to master 0. A starvation counter hands master 1 one grant
//   after STARVE_MAX consecutive denied cycles.
//   Read data (or an error response) returns exactly one cycle after the grant.
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   m0_req/we/un_sign/byte_mask/addr/wdata -> m0_gnt, m0_rvalid, m0_rdata, m0_err
//   m1_req/addr               -> m1_gnt, m1_rvalid, m1_rdata
//   s_en, s_we, s_addr, s_wdata -> memory;  s_rdata <- memory (one cycle after a read)
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_un_sign,
    input  logic [3:0]  m0_byte_mask,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        s_en,
    output logic [3:0]  s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata
);

    logic [3:0]  starve_cnt;
    logic        resp_valid;
    logic        resp_owner;   // 0 = master 0, 1 = master 1
    logic        resp_err;
    logic [3:0]  resp_mask;
    logic        resp_un_sign;
    logic [1:0]  resp_off;

    logic        m1_pri;
    logic        m0_ok;
    logic        m1_ok;
    logic        rsp_load;
    logic [31:0] raw;
    logic [31:0] ext;
    logic [31:0] rdata;

    // Master 1 overrides the default priority only once it has been starved.
    assign m1_pri = m1_req && (starve_cnt == 4'(STARVE_MAX));
    assign m1_gnt = m1_req && (m1_pri || !m0_req);
    assign m0_gnt = m0_req && !m1_pri;

    // Size/offset legality; unlisted mask codes are illegal.
    always_comb begin
        m0_ok = 1'b0;
        case (m0_byte_mask)
            4'b0001: m0_ok = 1'b1;
            4'b0011: m0_ok = !m0_addr[0];
            4'b1111: m0_ok = (m0_addr[1:0] == 2'b00);
            default: m0_ok = 1'b0;
        endcase
    end
    assign m1_ok = (m1_addr[1:0] == 2'b00);

    // Memory side: only a legal granted access touches the memory.
    always_comb begin
        s_en    = 1'b0;
        s_we    = 4'b0000;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        if (m1_gnt && m1_ok) begin
            s_en   = 1'b1;
            s_addr = {m1_addr[31:2], 2'b00};
        end else if (m0_gnt && m0_ok) begin
            s_en   = 1'b1;
            s_addr = {m0_addr[31:2], 2'b00};
            if (m0_we) begin
                s_we    = m0_byte_mask << m0_addr[1:0];
                s_wdata = m0_wdata << {m0_addr[1:0], 3'b000};
            end
        end
    end

    // Every grant produces a response except a legal store.
    assign rsp_load = m1_gnt || (m0_gnt && (!m0_we || !m0_ok));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt   <= 4'd0;
            resp_valid   <= 1'b0;
            resp_owner   <= 1'b0;
            resp_err     <= 1'b0;
            resp_mask    <= 4'd0;
            resp_un_sign <= 1'b0;
            resp_off     <= 2'd0;
        end else begin
            if (!m1_req || m1_gnt)
                starve_cnt <= 4'd0;
            else if (starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;

            resp_valid <= rsp_load;
            if (rsp_load) begin
                resp_owner   <= m1_gnt;
                resp_err     <= m1_gnt ? !m1_ok : !m0_ok;
                resp_mask    <= m1_gnt ? 4'b1111 : m0_byte_mask;
                resp_un_sign <= m1_gnt ? 1'b1 : m0_un_sign;
                resp_off     <= m1_gnt ? m1_addr[1:0] : m0_addr[1:0];
            end
        end
    end

    // Read return: shift the addressed lane down, then extend to 32 bits.
    assign raw = s_rdata >> {resp_off, 3'b000};

    always_comb begin
        ext = raw;
        case (resp_mask)
            4'b0001: ext = {{24{!resp_un_sign && raw[7]}}, raw[7:0]};
            4'b0011: ext = {{16{!resp_un_sign && raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign rdata     = resp_err ? 32'h0 : ext;

    assign m0_rvalid = resp_valid && !resp_owner;
    assign m0_rdata  = m0_rvalid ? rdata : 32'h0;
    assign m0_err    = m0_rvalid && resp_err;
    assign m1_rvalid = resp_valid && resp_owner;
    assign m1_rdata  = m1_rvalid ? rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter with a byte-addressed reference model.
module tb_mem_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_un_sign;
    logic [3:0]  m0_byte_mask;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        s_en;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_un_sign(m0_un_sign),
        .m0_byte_mask(m0_byte_mask), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    // Memory attached to the DUT (4 KB, word array, one-cycle read).
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q = 32'h0;
    always @(posedge clk) begin
        if (s_en) begin
            for (int b = 0; b < 4; b++)
                if (s_we[b]) mem[s_addr[11:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            if (s_we == 4'b0000) rd_q <= mem[s_addr[11:2]];
        end
    end
    assign s_rdata = rd_q;

    // Reference model state: byte memory, starvation count, expected response.
    logic [7:0]  ref_mem [0:4095];
    int          starve;
    logic        e_rv0, e_err0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
    logic        lg0, lg1, dut_g1;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_word(input int widx, input logic [31:0] w);
        mem[widx] = w;
        for (int b = 0; b < 4; b++) ref_mem[4*widx + b] = w[8*b +: 8];
    endtask

    task automatic clear_model();
        starve = 0;
        e_rv0 = 0; e_err0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0;
    endtask

    // One clock: check at negedge against the model, advance model at posedge.
    task automatic step();
        logic g0, g1, ok, xen, nv0, ne0, nv1;
        logic [3:0]  xwe;
        logic [31:0] xaddr, v, nd0, nd1;
        int n, off, a;
        @(negedge clk);
        g1 = m1_req && (starve == SM || !m0_req);
        g0 = m0_req && !g1;
        chk("m0_gnt", m0_gnt, g0);
        chk("m1_gnt", m1_gnt, g1);
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m0_err", m0_err, e_err0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("m1_rdata", m1_rdata, e_rd1);
        xen = 0; xwe = 0; xaddr = 0;
        nv0 = 0; ne0 = 0; nd0 = 0; nv1 = 0; nd1 = 0;
        if (g0) begin
            off = int'(m0_addr[1:0]);
            a   = int'(m0_addr[11:0]);
            n   = (m0_byte_mask == 4'b0001) ? 1 : (m0_byte_mask == 4'b0011) ? 2 :
                  (m0_byte_mask == 4'b1111) ? 4 : 0;
            ok  = (n != 0) && (off % n == 0);
            if (!ok) begin
                nv0 = 1; ne0 = 1;
            end else begin
                xen = 1; xaddr = {m0_addr[31:2], 2'b00};
                if (m0_we) begin
                    xwe = 4'((int'(m0_byte_mask) << off) & 15);
                    chk("s_wdata", s_wdata, m0_wdata << (8*off));
                    for (int i = 0; i < n; i++) ref_mem[a + i] = m0_wdata[8*i +: 8];
                end else begin
                    v = 0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
                    if (!m0_un_sign && n == 1 && v[7])  v = v | 32'hFFFFFF00;
                    if (!m0_un_sign && n == 2 && v[15]) v = v | 32'hFFFF0000;
                    nv0 = 1; nd0 = v;
                end
            end
        end
        if (g1) begin
            nv1 = 1;
            if (m1_addr[1:0] == 2'b00) begin
                a = int'(m1_addr[11:0]);
                xen = 1; xaddr = {m1_addr[31:2], 2'b00};
                nd1 = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
            end
        end
        chk("s_en", s_en, xen);
        chk("s_we", s_we, xwe);
        if (xen) chk("s_addr", s_addr, xaddr);
        if (!g0 && !g1) begin
            chk("s_addr_idle", s_addr, 0);
            chk("s_wdata_idle", s_wdata, 0);
        end
        dut_g1 = m1_gnt;
        lg0 = g0; lg1 = g1;
        @(posedge clk);
        if (rst) clear_model();
        else begin
            starve = (!m1_req || g1) ? 0 : ((starve + 1 > SM) ? SM : starve + 1);
            e_rv0 = nv0; e_err0 = ne0; e_rd0 = nd0; e_rv1 = nv1; e_rd1 = nd1;
        end
        #1;
    endtask

    task automatic drive0(input logic r, input logic we, input logic un,
                          input logic [3:0] m, input logic [31:0] ad, input logic [31:0] wd);
        m0_req = r; m0_we = we; m0_un_sign = un; m0_byte_mask = m; m0_addr = ad; m0_wdata = wd;
    endtask

    task automatic rnd_drive();
        int r;
        logic [3:0] m;
        logic [31:0] ad;
        if (!m0_req || lg0) begin
            r = $urandom_range(0, 9);
            m = (r < 3) ? 4'b0001 : (r < 6) ? 4'b0011 : (r < 9) ? 4'b1111 : 4'($urandom);
            ad = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0)
                ad = (m == 4'b1111) ? {ad[31:2], 2'b00} : (m == 4'b0011) ? {ad[31:1], 1'b0} : ad;
            drive0($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), m, ad, $urandom);
        end
        if (!m1_req || lg1) begin
            m1_req  = $urandom_range(0, 2) != 0;
            m1_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 4095))
                                                  : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        end
    endtask

    logic [9:0] gseq;

    initial begin
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        clear_model();
        lg0 = 0; lg1 = 0; dut_g1 = 0;
        drive0(0, 0, 0, 4'b0001, 0, 0);
        m1_req = 0; m1_addr = 0;
        rst = 1;
        #1;
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_s_en", s_en, 0);
        step(); step();
        rst = 0;
        step();

        // Fetch only.
        set_word(32'h100 >> 2, 32'hDEADBEEF);
        m1_req = 1; m1_addr = 32'h100;
        step();
        m1_req = 0;
        chk("fetch_rdata", m1_rdata, 32'hDEADBEEF);
        chk("fetch_rvalid", m1_rvalid, 1);

        // Signed / unsigned byte load.
        set_word(32'h200 >> 2, 32'h00008F00);
        drive0(1, 0, 0, 4'b0001, 32'h201, 0);
        step();
        chk("lb_signed", m0_rdata, 32'hFFFFFF8F);
        drive0(1, 0, 1, 4'b0001, 32'h201, 0);
        step();
        chk("lb_unsigned", m0_rdata, 32'h0000008F);

        // Half store then word load of the same word.
        drive0(1, 1, 0, 4'b0011, 32'h302, 32'h00001234);
        step();
        drive0(1, 0, 0, 4'b1111, 32'h300, 0);
        step();
        drive0(0, 0, 0, 4'b0001, 0, 0);
        chk("sh_then_lw", {16'h0, m0_rdata[31:16]}, 32'h1234);
        step();

        // Continuous contention.
        drive0(1, 0, 0, 4'b1111, 32'h40, 0);
        m1_req = 1; m1_addr = 32'h80;
        gseq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            gseq = {gseq[8:0], dut_g1};
        end
        chk("contend_seq", {22'h0, gseq}, {22'h0, 10'b0000100001});
        drive0(0, 0, 0, 4'b0001, 0, 0); m1_req = 0;
        step();

        // Misaligned word load, misaligned half store.
        drive0(1, 0, 0, 4'b1111, 32'h402, 0);
        step();
        chk("mis_lw_err", {m0_rvalid, m0_err}, 2'b11);
        chk("mis_lw_rdata", m0_rdata, 0);
        drive0(1, 1, 0, 4'b0011, 32'h403, 32'hFFFF);
        step();
        drive0(0, 0, 0, 4'b0001, 0, 0);
        chk("mis_sh_err", {m0_rvalid, m0_err}, 2'b11);
        chk("mis_sh_rdata", m0_rdata, 0);
        step();

        // Reset while a load response is pending (starve count non-zero too).
        drive0(1, 0, 0, 4'b1111, 32'h200, 0);
        m1_req = 1; m1_addr = 32'h100;
        step();
        rst = 1;
        drive0(0, 0, 0, 4'b0001, 0, 0); m1_req = 0;
        clear_model();
        #1;
        chk("rstp_m0_rvalid", m0_rvalid, 0);
        chk("rstp_m0_rdata", m0_rdata, 0);
        chk("rstp_starve", {28'h0, dut.starve_cnt}, 0);
        step();
        rst = 0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rnd_drive();
            step();
        end
        drive0(0, 0, 0, 4'b0001, 0, 0); m1_req = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Registered two-master arbiter in front of the single-port core memory, replacing the combinational bus switch. It shares the memory between the execute stage (master 0: loads/stores) and the fetch unit (master 1: instruction reads). It uses a request/grant handshake with fixed priority to master 0 and a starvation guard for fetch. It performs byte-lane steering, write-strobe generation, load sign/zero extension and misalignment detection, and returns read data one cycle after grant.

## Interface
- STARVE_MAX, 4: consecutive denied fetch cycles after which master 1 takes priority for one grant (1..15)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 access request, held until granted
- m0_we  in  1  1 = store, 0 = load
- m0_un_sign  in  1  load extension: 1 = zero-extend, 0 = sign-extend
- m0_byte_mask  in  4  size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; other codes are illegal
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  load data / error response valid
- m0_rdata  out  32  extended load data
- m0_err  out  1  misaligned or illegal-mask response, valid with m0_rvalid
- m1_req  in  1  fetch request, word read only
- m1_addr  in  32  fetch byte address
- m1_gnt  out  1  fetch accepted this cycle (combinational)
- m1_rvalid  out  1  fetch data valid
- m1_rdata  out  32  fetched word
- s_en  out  1  memory access enable
- s_we  out  4  per-byte write strobes
- s_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- s_wdata  out  32  lane-steered write data
- s_rdata  in  32  memory read data, valid the cycle after s_en with s_we==0

## Operation
- Grant rule: at most one grant per cycle.
  - Default priority is master 0.
  - Master 1 wins instead when starve_cnt==STARVE_MAX and m1_req=1.
  - A requester with req=0 never receives gnt.
- starve_cnt (4-bit register):
  - Increments when m1_req=1 and m1_gnt=0, saturating at STARVE_MAX.
  - Clears on m1_gnt or when m1_req=0.
- Alignment: off=addr[1:0].
  - Byte: any off is legal.
  - Half: off must be 0 or 2.
  - Word: off must be 0.
  - A misaligned or illegal-mask master 0 request is still granted (m0_gnt=1), but s_en=0 and no memory access occurs.
  - Next cycle: m0_rvalid=1, m0_err=1, m0_rdata=0, for loads and stores alike.
  - A misaligned master 1 request (off!=0) behaves the same way, but has no error port: m1_rvalid=1 with m1_rdata=0.
- Store, granted and legal:
  - s_en=1, s_we=byte_mask<<off, s_wdata=m0_wdata<<(8*off).
  - No rvalid response; the store completes at grant.
- Load or fetch, granted and legal:
  - s_en=1, s_we=0.
  - Response registers capture owner, mask, un_sign and off.
- Read return, cycle after grant:
  - Raw data is s_rdata>>(8*off).
  - Byte loads extend bit 7; half loads extend bit 15; word loads pass through unchanged.
  - Extension is zero-fill when un_sign=1, otherwise replicate the sign bit.
  - Result appears on the owner's rdata with rvalid=1 for exactly one cycle.
- When no grant is issued: s_en=0, s_we=0, and s_addr/s_wdata=0.

## Timing
- Reset values:
  - All registers (starve_cnt, resp_valid, resp_owner, resp_err, resp_mask, resp_un_sign, resp_off) are 0.
  - m0_rvalid, m1_rvalid, m0_err = 0; m0_rdata, m1_rdata = 0.
  - gnt outputs and s_* outputs are 0 because they are derived from req inputs and no grant is active.
- Latency:
  - Grant is in the same cycle as the request when the master wins.
  - Read data arrives exactly 1 cycle after grant.
  - Full throughput is one access per cycle; back-to-back grants pipeline, and a response and a new grant may coincide.
- Handshake:
  - A master holds req/addr/data stable until gnt.
  - The request is consumed at the rising edge where req&gnt.
  - Master 0 store followed by master 0 load to the same word on consecutive cycles returns the new data, because memory is write-first at the cycle boundary.
- Simultaneous requests: master 0 wins until starve_cnt reaches STARVE_MAX. Master 1 then wins one cycle, starve_cnt clears, and priority reverts.
- rdata is 0 whenever rvalid=0.
- Reset mid-operation:
  - An asynchronous rst pending a read response drops that response, and no rvalid follows.
  - starve_cnt clears.

## Test plan
- Fetch only:
  - m1_req with m1_addr=0x100 and memory word 0xDEADBEEF.
  - Required: m1_gnt the same cycle; next cycle m1_rvalid=1, m1_rdata=0xDEADBEEF, s_addr=0x100.
- Signed/unsigned byte load from word 0x00008F00 at addr 0x201:
  - un_sign=0 -> m0_rdata=0xFFFFFF8F.
  - un_sign=1 -> m0_rdata=0x0000008F.
- Half store 0x1234 to addr 0x302:
  - Required: s_we=4'b1100, s_wdata=0x12340000.
  - A following word load from 0x300 returns 0x1234xxxx.
- Continuous contention with m0_req=1 and m1_req=1 every cycle, STARVE_MAX=4:
  - Grants follow m0,m0,m0,m0,m1 and then repeat.
  - m1 never waits more than 5 cycles.
- Misalignment: m0 word load at 0x402.
  - Required: m0_gnt=1, s_en=0; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0.
  - Repeat for a half store at 0x403 with the same response.
- Reset during a pending load:
  - Assert rst in the cycle after grant.
  - Required: m0_rvalid stays 0, starve_cnt=0, and all outputs return to 0.
